// File: rtl/qcw_sequencer.sv
// QCW burst sequencer: start pulse, saturating linear setpoint ramp, done pulse,
// enforced off-time between bursts and lockout after repeated over-current aborts.
module qcw_sequencer #(
  parameter int TICK_DIV        = 16,
  parameter int COOLDOWN_CYCLES = 1000000,
  parameter int FAULT_LIMIT     = 3
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        trigger,
  input  logic        clear_fault,
  input  logic [19:0] pulse_len,
  input  logic [9:0]  ramp_inc,
  input  logic        qcw_halt,
  output logic        qcw_start,
  output logic        qcw_done,
  output logic        qcw_active,
  output logic [9:0]  power_setpoint,
  output logic [3:0]  fault_count,
  output logic        lockout
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_RAMP     = 3'd2,
    S_ABORT    = 3'd3,
    S_DONE     = 3'd4,
    S_COOLDOWN = 3'd5,
    S_LOCKOUT  = 3'd6
  } state_t;

  state_t          state_r;
  state_t          state_nx;
  logic [19:0]     plen_r;
  logic [9:0]      inc_r;
  logic [19:0]     cyc_r;
  logic [TW-1:0]   tick_r;
  logic [CW-1:0]   cd_r;
  logic [19:0]     plen_eff_s;
  logic [10:0]     sum_s;
  logic [9:0]      sat_s;
  logic [TW-1:0]   tick_inc_s;

  // Ramp arithmetic: 11-bit sum clamped to full scale, and the next step-tick value
  always_comb begin
    plen_eff_s = (plen_r == 20'd0) ? 20'd1 : plen_r;
    sum_s      = {1'b0, power_setpoint} + {1'b0, inc_r};
    sat_s      = sum_s[10] ? 10'd1023 : sum_s[9:0];
    tick_inc_s = tick_r + TW'(1);
  end

  // State register
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; halt outranks enable-drop, which outranks normal completion
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: begin
        if (enable && trigger) state_nx = S_START;
        else                   state_nx = S_IDLE;
      end
      S_START: state_nx = S_RAMP;
      S_RAMP: begin
        if (qcw_halt)                  state_nx = S_ABORT;
        else if (!enable)              state_nx = S_DONE;
        else if (cyc_r >= plen_eff_s)  state_nx = S_DONE;
        else                           state_nx = S_RAMP;
      end
      S_ABORT: begin
        if (fault_count >= 4'(FAULT_LIMIT)) state_nx = S_LOCKOUT;
        else                                state_nx = S_COOLDOWN;
      end
      S_DONE: state_nx = S_COOLDOWN;
      S_COOLDOWN: begin
        if (cd_r >= CW'(COOLDOWN_CYCLES)) state_nx = S_IDLE;
        else                              state_nx = S_COOLDOWN;
      end
      S_LOCKOUT: begin
        if (clear_fault) state_nx = S_IDLE;
        else             state_nx = S_LOCKOUT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Registered outputs and datapath, all computed from the state being entered
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      qcw_start      <= 1'b0;
      qcw_done       <= 1'b0;
      qcw_active     <= 1'b0;
      lockout        <= 1'b0;
      power_setpoint <= 10'd0;
      fault_count    <= 4'd0;
      plen_r         <= 20'd0;
      inc_r          <= 10'd0;
      cyc_r          <= 20'd0;
      tick_r         <= '0;
      cd_r           <= '0;
    end else begin
      qcw_start  <= (state_nx == S_START);
      qcw_done   <= (state_nx == S_ABORT) || (state_nx == S_DONE);
      qcw_active <= (state_nx == S_RAMP);
      lockout    <= (state_nx == S_LOCKOUT);

      if (state_nx == S_START) begin
        plen_r <= pulse_len;
        inc_r  <= ramp_inc;
      end else begin
        plen_r <= plen_r;
        inc_r  <= inc_r;
      end

      // cyc_r counts RAMP cycles including the one being entered
      if (state_nx == S_RAMP) begin
        cyc_r <= cyc_r + 20'd1;
        if (tick_inc_s == TW'(TICK_DIV)) begin
          tick_r         <= '0;
          power_setpoint <= sat_s;
        end else begin
          tick_r         <= tick_inc_s;
          power_setpoint <= power_setpoint;
        end
      end else begin
        cyc_r          <= 20'd0;
        tick_r         <= '0;
        power_setpoint <= 10'd0;
      end

      if (state_nx == S_COOLDOWN) begin
        cd_r <= (state_r == S_COOLDOWN) ? cd_r + CW'(1) : CW'(1);
      end else begin
        cd_r <= '0;
      end

      if (state_nx == S_ABORT) begin
        fault_count <= (fault_count == 4'd15) ? 4'd15 : fault_count + 4'd1;
      end else if (state_nx == S_DONE) begin
        fault_count <= 4'd0;
      end else if ((state_r == S_LOCKOUT) && (state_nx == S_IDLE)) begin
        fault_count <= 4'd0;
      end else begin
        fault_count <= fault_count;
      end
    end
  end

endmodule

// File: tb/tb_qcw_sequencer.sv
// Directed bench for qcw_sequencer with TICK_DIV=1, COOLDOWN_CYCLES=20, FAULT_LIMIT=3.
module tb_qcw_sequencer;

  localparam int CD = 20;

  logic        system_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        trigger;
  logic        clear_fault;
  logic [19:0] pulse_len;
  logic [9:0]  ramp_inc;
  logic        qcw_halt;
  logic        qcw_start;
  logic        qcw_done;
  logic        qcw_active;
  logic [9:0]  power_setpoint;
  logic [3:0]  fault_count;
  logic        lockout;

  int n_tests = 0;
  int n_fail  = 0;

  qcw_sequencer #(.TICK_DIV(1), .COOLDOWN_CYCLES(CD), .FAULT_LIMIT(3)) dut (
    .system_clk     (system_clk),
    .reset          (reset),
    .enable         (enable),
    .trigger        (trigger),
    .clear_fault    (clear_fault),
    .pulse_len      (pulse_len),
    .ramp_inc       (ramp_inc),
    .qcw_halt       (qcw_halt),
    .qcw_start      (qcw_start),
    .qcw_done       (qcw_done),
    .qcw_active     (qcw_active),
    .power_setpoint (power_setpoint),
    .fault_count    (fault_count),
    .lockout        (lockout)
  );

  always #5 system_clk = ~system_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one clock; observation point is 1 time unit after the rising edge
  task automatic cyc();
    @(posedge system_clk);
    #1;
  endtask

  // issue a one-cycle trigger from IDLE; returns observing the START cycle
  task automatic start_burst(input logic [19:0] plen, input logic [9:0] inc);
    pulse_len = plen;
    ramp_inc  = inc;
    trigger   = 1'b1;
    cyc();
    trigger   = 1'b0;
    chk("start_pulse", {31'd0, qcw_start}, 32'd1);
  endtask

  // burst halted while RAMP cycle hc is visible; returns observing the ABORT cycle
  task automatic abort_burst(input int hc);
    start_burst(20'd8, 10'd100);
    repeat (hc) cyc();
    qcw_halt = 1'b1;
    cyc();
    qcw_halt = 1'b0;
    chk("abort_done", {31'd0, qcw_done}, 32'd1);
    chk("abort_sp0", {22'd0, power_setpoint}, 32'd0);
  endtask

  task automatic wait_idle();
    repeat (CD + 1) cyc();
  endtask

  initial begin
    int n;
    int starts;
    reset = 1'b1; enable = 1'b0; trigger = 1'b0; clear_fault = 1'b0;
    pulse_len = 20'd0; ramp_inc = 10'd0; qcw_halt = 1'b0;
    repeat (3) cyc();
    chk("rst_out", {18'd0, qcw_start, qcw_done, qcw_active, lockout, fault_count, power_setpoint}, 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    cyc();

    // normal burst: 100..800 then done with setpoint 0
    start_burst(20'd8, 10'd100);
    chk("start_sp", {22'd0, power_setpoint}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("ramp_sp", {22'd0, power_setpoint}, 32'(100 * k));
      chk("ramp_act", {31'd0, qcw_active}, 32'd1);
    end
    cyc();
    chk("norm_done", {31'd0, qcw_done}, 32'd1);
    chk("norm_sp0", {22'd0, power_setpoint}, 32'd0);
    chk("norm_act0", {31'd0, qcw_active}, 32'd0);
    chk("norm_fc", {28'd0, fault_count}, 32'd0);

    // hold trigger from DONE: START appears after 20 cooldown cycles + 1 IDLE cycle
    pulse_len = 20'd4; ramp_inc = 10'd600; trigger = 1'b1;
    n = 0;
    while (n < 100) begin
      cyc();
      n++;
      if (qcw_start) break;
    end
    trigger = 1'b0;
    chk("cooldown_len", n, 32'd22);

    // saturation: 600, 1023, 1023, 1023, then 0
    cyc(); chk("sat1", {22'd0, power_setpoint}, 32'd600);
    cyc(); chk("sat2", {22'd0, power_setpoint}, 32'd1023);
    cyc(); chk("sat3", {22'd0, power_setpoint}, 32'd1023);
    cyc(); chk("sat4", {22'd0, power_setpoint}, 32'd1023);
    cyc(); chk("sat_done", {21'd0, qcw_done, power_setpoint}, 32'h400);

    // trigger pulsed during cooldown is dropped
    starts = 0;
    repeat (3) cyc();
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      starts += int'(qcw_start);
    end
    chk("cd_trig_drop", starts, 32'd0);

    // halt on RAMP cycle 3; halt during cooldown ignored
    abort_burst(3);
    chk("halt_fc1", {28'd0, fault_count}, 32'd1);
    chk("halt_act0", {31'd0, qcw_active}, 32'd0);
    cyc();
    qcw_halt = 1'b1;
    cyc();
    qcw_halt = 1'b0;
    chk("cd_halt_ign", {26'd0, qcw_done, lockout, fault_count}, 32'd1);
    wait_idle();

    // clean burst resets the count
    start_burst(20'd8, 10'd100);
    repeat (9) cyc();
    chk("clean_done", {31'd0, qcw_done}, 32'd1);
    chk("clean_fc0", {28'd0, fault_count}, 32'd0);
    wait_idle();

    // three aborts -> lockout; third coincides with the final RAMP cycle
    abort_burst(2);
    chk("lk_fc1", {28'd0, fault_count}, 32'd1);
    wait_idle();
    abort_burst(5);
    chk("lk_fc2", {28'd0, fault_count}, 32'd2);
    wait_idle();
    abort_burst(8);
    chk("halt_final_fc3", {28'd0, fault_count}, 32'd3);
    cyc();
    chk("lockout_on", {31'd0, lockout}, 32'd1);
    chk("lockout_fc", {28'd0, fault_count}, 32'd3);
    starts = 0;
    trigger = 1'b1; qcw_halt = 1'b1;
    repeat (5) begin
      cyc();
      starts += int'(qcw_start);
    end
    trigger = 1'b0; qcw_halt = 1'b0;
    chk("lk_trig_drop", starts, 32'd0);
    chk("lk_hold", {27'd0, lockout, fault_count}, 32'h13);
    clear_fault = 1'b1;
    cyc();
    clear_fault = 1'b0;
    chk("clear_lk", {27'd0, lockout, fault_count}, 32'd0);
    cyc();

    // enable drop on the final cycle: DONE, count cleared rather than bumped
    abort_burst(4);
    chk("pre_fc1", {28'd0, fault_count}, 32'd1);
    wait_idle();
    start_burst(20'd8, 10'd100);
    repeat (8) cyc();
    enable = 1'b0;
    cyc();
    chk("en_final_done", {31'd0, qcw_done}, 32'd1);
    chk("en_final_fc", {27'd0, lockout, fault_count}, 32'd0);
    enable = 1'b1;
    wait_idle();

    // enable drop mid-ramp ends the burst early
    start_burst(20'd8, 10'd100);
    repeat (3) cyc();
    enable = 1'b0;
    cyc();
    chk("early_done", {21'd0, qcw_done, power_setpoint}, 32'h400);
    enable = 1'b1;
    wait_idle();

    // pulse_len=0 behaves as a single RAMP cycle
    start_burst(20'd0, 10'd5);
    cyc();
    chk("plen0_ramp", {21'd0, qcw_active, power_setpoint}, 32'h405);
    cyc();
    chk("plen0_done", {31'd0, qcw_done}, 32'd1);
    wait_idle();

    // async reset mid-RAMP clears outputs before the next edge
    start_burst(20'd8, 10'd100);
    repeat (3) cyc();
    chk("pre_rst_sp", {22'd0, power_setpoint}, 32'd300);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", {20'd0, qcw_done, qcw_active, power_setpoint}, 32'd0);
    #2;
    reset = 1'b0;
    cyc();
    chk("post_rst", {20'd0, qcw_done, qcw_active, power_setpoint}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
